// File: rtl/bn_pkg.sv
// bn_pkg: shared state encoding, BN factor codes and config-code validity check
package bn_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] F_1    = 4'b0100;
  localparam logic [3:0] F_0_25 = 4'b1000;
  localparam logic [3:0] F_0_5  = 4'b0001;
  localparam logic [3:0] F_0_75 = 4'b1001;
  localparam logic [3:0] F_1_5  = 4'b0101;
  localparam logic [3:0] F_2    = 4'b0010;
  localparam logic [3:0] F_2_25 = 4'b1010;
  localparam logic [3:0] F_3    = 4'b0110;
  localparam logic [3:0] F_4    = 4'b1100;
  localparam logic [3:0] F_4_5  = 4'b1101;
  localparam logic [3:0] F_6    = 4'b1110;
  localparam logic [3:0] F_8    = 4'b0011;
  function automatic logic factor_valid(input logic [3:0] f);
    return !(f == 4'b0000 || f == 4'b0111 || f == 4'b1011 || f == 4'b1111);
  endfunction
endpackage

// File: rtl/batch_normalization.sv
// batch_normalization: saturating u + addend + factor*z using shift-add factors with floor shifts
module batch_normalization
  import bn_pkg::*;
#(
  parameter int WIDTH        = 6,
  parameter int ADDEND_WIDTH = WIDTH - 2
) (
  input  logic [WIDTH-1:0]        u,
  input  logic [WIDTH-1:0]        z,
  input  logic [3:0]              factor,
  input  logic [ADDEND_WIDTH-1:0] addend,
  output logic [WIDTH-1:0]        result
);
  localparam int SW = WIDTH + 5;
  localparam logic signed [SW-1:0] MAXV = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  logic signed [SW-1:0] ux, zx, ax, fz, s;
  assign ux = SW'($signed(u));
  assign zx = SW'($signed(z));
  assign ax = SW'($signed(addend));
  // scaled z for the selected factor code; invalid codes never reach the regfile
  always_comb begin
    fz = '0;
    case (factor)
      F_1:     fz = zx;
      F_0_25:  fz = zx >>> 2;
      F_0_5:   fz = zx >>> 1;
      F_0_75:  fz = (zx >>> 1) + (zx >>> 2);
      F_1_5:   fz = zx + (zx >>> 1);
      F_2:     fz = zx <<< 1;
      F_2_25:  fz = (zx <<< 1) + (zx >>> 2);
      F_3:     fz = (zx <<< 1) + zx;
      F_4:     fz = zx <<< 2;
      F_4_5:   fz = (zx <<< 2) + (zx >>> 1);
      F_6:     fz = (zx <<< 2) + (zx <<< 1);
      F_8:     fz = zx <<< 3;
      default: fz = '0;
    endcase
  end
  assign s = ux + ax + fz;
  assign result = s > MAXV ? MAXV[WIDTH-1:0] : s < MINV ? MINV[WIDTH-1:0] : s[WIDTH-1:0];
endmodule

// File: rtl/bn_scheduler.sv
// bn_scheduler: time-multiplexes one BN datapath over N_NEURONS, one neuron per cycle
module bn_scheduler
  import bn_pkg::*;
#(
  parameter int WIDTH        = 6,
  parameter int ADDEND_WIDTH = WIDTH - 2,
  parameter int N_NEURONS    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0] cfg_addr,
  input  logic [3:0]                   cfg_factor,
  input  logic [ADDEND_WIDTH-1:0]      cfg_addend,
  output logic                         cfg_err,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_NEURONS*WIDTH-1:0]   u_vec,
  input  logic [N_NEURONS*WIDTH-1:0]   z_vec,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_NEURONS*WIDTH-1:0]   u_out_vec
);
  localparam int AW = $clog2(N_NEURONS);
  localparam logic [AW:0]   NN   = (AW+1)'(N_NEURONS);
  localparam logic [AW-1:0] LAST = AW'(N_NEURONS - 1);
  logic [1:0]                 state;
  logic [AW-1:0]              idx;
  logic [N_NEURONS*WIDTH-1:0] u_reg, z_reg, res_vec, res_next;
  logic [3:0]                 fac [N_NEURONS];
  logic [3:0]                 f_snap [N_NEURONS];
  logic [ADDEND_WIDTH-1:0]    add [N_NEURONS];
  logic [ADDEND_WIDTH-1:0]    a_snap [N_NEURONS];
  logic [WIDTH-1:0]           bn_out;
  logic                       cfg_ok;
  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign cfg_ok = state == S_IDLE && {1'b0, cfg_addr} < NN && factor_valid(cfg_factor)
                  && !(cfg_factor == F_8 && cfg_addend != '0);
  batch_normalization #(.WIDTH(WIDTH), .ADDEND_WIDTH(ADDEND_WIDTH)) u_bn (
    .u(u_reg[idx*WIDTH +: WIDTH]),
    .z(z_reg[idx*WIDTH +: WIDTH]),
    .factor(f_snap[idx]),
    .addend(a_snap[idx]),
    .result(bn_out)
  );
  // staging vector with the current neuron's result merged in
  always_comb begin
    res_next = res_vec;
    res_next[idx*WIDTH +: WIDTH] = bn_out;
  end
  // config regfile; writes only land in IDLE with a legal code/address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        fac[i] <= F_1;
        add[i] <= '0;
      end
      cfg_err <= 1'b0;
    end else begin
      if (cfg_we && cfg_ok) begin
        fac[cfg_addr] <= cfg_factor;
        add[cfg_addr] <= cfg_addend;
      end
      cfg_err <= cfg_we && !cfg_ok;
    end
  end
  // batch FSM: snapshot operands and parameters, sweep neurons, publish on completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      u_reg     <= '0;
      z_reg     <= '0;
      res_vec   <= '0;
      u_out_vec <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        f_snap[i] <= F_1;
        a_snap[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          state  <= S_RUN;
          idx    <= '0;
          u_reg  <= u_vec;
          z_reg  <= z_vec;
          f_snap <= fac;
          a_snap <= add;
        end
        S_RUN: begin
          res_vec <= res_next;
          idx     <= idx == LAST ? '0 : idx + 1'b1;
          if (idx == LAST) begin
            state     <= S_DONE;
            u_out_vec <= res_next;
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
